meas_frame_serializer: RTL

- Parametrised successor to the single-value byte serializer feeding the UART TX path.
- Accepts a command byte and snapshots all NUM_CHANNELS measurement words coherently.
- Emits a framed byte stream over a valid/ready link: header, channel id, payload bytes, XOR checksum.
- Supports single-channel and all-channel burst modes, selectable byte order, and an error frame for bad channel indices.

---
 rtl/meas_frame_serializer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/meas_frame_serializer.sv
// meas_frame_serializer: snapshots NUM_CHANNELS measurement words on a command
// and streams a framed byte sequence (header, id, payload, XOR checksum).
module meas_frame_serializer #(
    parameter int COUNTER_BITS = 32,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int MSB_FIRST    = 0,
    parameter logic [DATA_WIDTH-1:0] HEADER = 'hA5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           cmd_data,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [NUM_CHANNELS*COUNTER_BITS-1:0] meas_bus,
    output logic [DATA_WIDTH-1:0]                tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 cmd_error
);

    localparam int BYTES = COUNTER_BITS / DATA_WIDTH;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MW    = NUM_CHANNELS * COUNTER_BITS;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ID,
        PAY,
        CHK
    } state_t;

    state_t                state;
    logic [MW-1:0]         snap;
    logic [6:0]            chan;
    logic                  burst;
    logic                  bad;
    logic [BW-1:0]         bidx;
    logic [DATA_WIDTH-1:0] chk;
    logic [BW-1:0]         pay_idx;
    logic [DATA_WIDTH-1:0] pay_byte;
    logic                  xfer;
    logic                  idx_bad;
    logic                  last_byte;
    logic                  more_chan;

    assign xfer       = tx_valid && tx_ready;
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign frame_done = (state == CHK) && xfer;
    assign idx_bad    = !cmd_data[7] &&
                        (int'(cmd_data[6:0]) >= NUM_CHANNELS);
    assign last_byte  = (int'(bidx) == BYTES - 1);
    assign more_chan  = burst && (int'(chan) < NUM_CHANNELS - 1);

    // Select the payload byte to load next: byte 0 when leaving ID,
    // byte bidx+1 while walking through PAY.
    always_comb begin
        int k;
        pay_idx = '0;
        if (state == PAY) begin
            pay_idx = bidx + BW'(1);
        end
        k = (MSB_FIRST != 0) ? (BYTES - 1 - int'(pay_idx))
                             : int'(pay_idx);
        pay_byte = snap[int'(chan)*COUNTER_BITS + k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Frame FSM; every output byte is registered and held until it transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            chan      <= '0;
            burst     <= 1'b0;
            bad       <= 1'b0;
            bidx      <= '0;
            chk       <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        snap      <= meas_bus;
                        burst     <= cmd_data[7];
                        bad       <= idx_bad;
                        chan      <= cmd_data[7] ? 7'd0 : cmd_data[6:0];
                        chk       <= '0;
                        bidx      <= '0;
                        cmd_error <= idx_bad;
                        tx_data   <= HEADER;
                        tx_valid  <= 1'b1;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state   <= ID;
                        tx_data <= bad ? '1 : DATA_WIDTH'(chan);
                    end
                end
                ID: begin
                    if (xfer) begin
                        chk  <= chk ^ tx_data;
                        bidx <= '0;
                        if (bad) begin
                            state   <= CHK;
                            tx_data <= chk ^ tx_data;
                        end else begin
                            state   <= PAY;
                            tx_data <= pay_byte;
                        end
                    end
                end
                PAY: begin
                    if (xfer) begin
                        chk <= chk ^ tx_data;
                        if (!last_byte) begin
                            bidx    <= bidx + BW'(1);
                            tx_data <= pay_byte;
                        end else if (more_chan) begin
                            chan    <= chan + 7'd1;
                            state   <= ID;
                            tx_data <= DATA_WIDTH'(chan + 7'd1);
                        end else begin
                            state   <= CHK;
                            tx_data <= chk ^ tx_data;
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
